// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state encodings shared by the chunked ALU sequencer and its slice.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return op <= 3'(OP_XOR);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational narrow ALU slice with carry chaining.
// Owns the SUB inversion of b and zeroes its output for reserved opcodes.
module alu_slice
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    input  logic         cin,
    output logic [W-1:0] y,
    output logic         cout
);

    logic [W-1:0] beff;
    logic [W:0]   sum;

    always_comb begin
        beff = (op == OP_SUB) ? ~b : b;
        sum  = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, cin};
        y    = is_arith(op)    ? sum[W-1:0] :
               (op == OP_AND)  ? (a & b)    :
               (op == OP_OR)   ? (a | b)    :
               (op == OP_XOR)  ? (a ^ b)    : '0;
        cout = is_arith(op) & sum[W];
    end

endmodule

// File: rtl/alu_chunk_sequencer.sv
// alu_chunk_sequencer: runs a wide ALU op through one narrow slice, LSB chunk first,
// with valid/ready handshakes toward issue logic and the register-file write port.
module alu_chunk_sequencer
    import alu_pkg::*;
#(
    parameter int CHUNK_W    = 4,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_op,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_a,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] out_result,
    output logic                          out_n,
    output logic                          out_z,
    output logic                          out_c,
    output logic                          out_v,
    output logic                          out_err
);

    localparam int W  = CHUNK_W * NUM_CHUNKS;
    localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    state_t             state;
    logic [2:0]         op;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [W-1:0]       res;
    logic [IW-1:0]      idx;
    logic               carry;
    logic               zacc;
    logic               n;
    logic               z;
    logic               c;
    logic               v;
    logic               err;
    logic [CHUNK_W-1:0] y;
    logic               cout;
    logic               cin;
    logic               last;
    logic               y_zero;
    logic               a_msb;
    logic               be_msb;
    logic               y_msb;

    assign cin    = (idx == '0) ? (op == OP_SUB) : carry;
    assign last   = idx == IW'(NUM_CHUNKS - 1);
    assign y_zero = y == '0;
    // On the final chunk the low slices of the shift registers hold the operand MSBs.
    assign a_msb  = a[CHUNK_W-1];
    assign be_msb = b[CHUNK_W-1] ^ (op == OP_SUB);
    assign y_msb  = y[CHUNK_W-1];

    alu_slice #(.W(CHUNK_W)) u_slice (
        .a    (a[CHUNK_W-1:0]),
        .b    (b[CHUNK_W-1:0]),
        .op   (op),
        .cin  (cin),
        .y    (y),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op    <= '0;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            zacc  <= 1'b0;
            n     <= 1'b0;
            z     <= 1'b0;
            c     <= 1'b0;
            v     <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op    <= in_op;
                    a     <= in_a;
                    b     <= in_b;
                    idx   <= '0;
                    zacc  <= 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    a     <= a >> CHUNK_W;
                    b     <= b >> CHUNK_W;
                    res   <= {y, res[W-1:CHUNK_W]};
                    carry <= cout;
                    zacc  <= zacc & y_zero;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        n     <= is_arith(op) & y_msb;
                        z     <= is_legal(op) & zacc & y_zero;
                        c     <= cout;
                        v     <= is_arith(op) & (a_msb == be_msb) & (y_msb != a_msb);
                        err   <= ~is_legal(op);
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Result and flags are masked outside DONE so a partial result is never visible.
    assign in_ready   = state == IDLE;
    assign out_valid  = state == DONE;
    assign out_result = out_valid ? res : '0;
    assign out_n      = out_valid & n;
    assign out_z      = out_valid & z;
    assign out_c      = out_valid & c;
    assign out_v      = out_valid & v;
    assign out_err    = out_valid & err;

endmodule

// File: tb/tb_alu_chunk_sequencer.sv
// tb_alu_chunk_sequencer: directed vectors with literal expectations plus a
// full-width arithmetic model checked against the DUT on every cycle.
module tb_alu_chunk_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'b000;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_n;
    logic        out_z;
    logic        out_c;
    logic        out_v;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
        logic        err;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t q[$];

    alu_chunk_sequencer #(.CHUNK_W(4), .NUM_CHUNKS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_n      (out_n),
        .out_z      (out_z),
        .out_c      (out_c),
        .out_v      (out_v),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Full-width reference: unsigned/signed integer arithmetic, no chunking.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        int   s;
        e = '{res: '0, n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0, acc: acc, seen: 1'b0};
        s = 0;
        case (op)
            3'b000: begin
                e.res = a + b;
                e.c   = (int'(a) + int'(b)) > 65535;
                s     = int'($signed(a)) + int'($signed(b));
            end
            3'b001: begin
                e.res = a - b;
                e.c   = a >= b;
                s     = int'($signed(a)) - int'($signed(b));
            end
            3'b010: e.res = a & b;
            3'b011: e.res = a | b;
            3'b100: e.res = a ^ b;
            default: e.err = 1'b1;
        endcase
        if (op <= 3'b001) begin
            e.n = e.res[15];
            e.v = (s > 32767) || (s < -32768);
        end
        e.z = !e.err && (e.res == 16'h0000);
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            cyc <= cyc + 1;
            if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, cyc));
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("model result", 32'(out_result), 32'(q[0].res));
                    chk("model flags", 32'({out_n, out_z, out_c, out_v, out_err}),
                        32'({q[0].n, q[0].z, q[0].c, q[0].v, q[0].err}));
                    chk("in_ready while done", 32'(in_ready), 32'd0);
                    if (!q[0].seen) begin
                        chk("latency", 32'(cyc - q[0].acc), 32'd5);
                        q[0].seen = 1'b1;
                    end
                end
            end else begin
                chk("idle outputs masked", 32'({out_result, out_n, out_z, out_c, out_v, out_err}), 32'd0);
            end
        end
    end

    task automatic do_op(input string nm, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [4:0] ef, input int hold);
        int k;
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, " ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, " valid"}, 32'(out_valid), 32'd1);
        chk({nm, " result"}, 32'(out_result), 32'(er));
        chk({nm, " flags"}, 32'({out_n, out_z, out_c, out_v, out_err}), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk({nm, " busy"}, 32'(in_ready), 32'd0);
            chk({nm, " held result"}, 32'(out_result), 32'(er));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " idle"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        #12;
        chk("reset", 32'({in_ready, out_valid, out_result, out_n, out_z, out_c, out_v, out_err}), 32'h1_0000_0 << 2);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // flags vector order: n z c v err
        do_op("add small", 3'b000, 16'h0005, 16'h0003, 16'h0008, 5'b00000, 0);
        do_op("sub neg",   3'b001, 16'h0000, 16'h0005, 16'hFFFB, 5'b10000, 0);
        do_op("sub zero",  3'b001, 16'h0005, 16'h0005, 16'h0000, 5'b01100, 0);
        do_op("add ovf",   3'b000, 16'h7FFF, 16'h0001, 16'h8000, 5'b10010, 0);
        do_op("add wrap",  3'b000, 16'hFFFF, 16'h0001, 16'h0000, 5'b01100, 0);
        do_op("xor",       3'b100, 16'hFFFF, 16'h0000, 16'hFFFF, 5'b00000, 0);
        do_op("and zero",  3'b010, 16'hF0F0, 16'h0F0F, 16'h0000, 5'b01000, 0);
        do_op("or",        3'b011, 16'h1234, 16'h0F00, 16'h1F34, 5'b00000, 0);
        do_op("sub ovf",   3'b001, 16'h8000, 16'h0001, 16'h7FFF, 5'b00110, 0);
        do_op("reserved",  3'b111, 16'h1234, 16'h5678, 16'h0000, 5'b00001, 0);
        do_op("hold",      3'b000, 16'h1234, 16'h1111, 16'h2345, 5'b00000, 3);
        chk("accept after hold", 32'(in_ready), 32'd1);
        do_op("after hold", 3'b001, 16'h0010, 16'h0001, 16'h000F, 5'b00100, 0);
        in_op = 3'b000;
        in_a = 16'h1111;
        in_b = 16'h2222;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort ready", 32'({in_ready, out_valid}), 32'b10);
        chk("abort result", 32'(out_result), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op("post reset", 3'b000, 16'h00FF, 16'h0001, 16'h0100, 5'b00000, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
